pw_psum_accum: RTL and testbench
================================

Name: pw_psum_accum

Overview:
- Pointwise (1x1) partial-sum accumulation stage, directly downstream of the depthwise 3x3 + ReLU stage.
- Per beat it consumes 4 ReLU'd 3x3 activations (one pixel, 4 input channels) and 4 matching 1x1 weights for one output channel.
- It forms the quantized 4-channel dot product and read-modify-writes the 8-bit partial sum held in the psum SRAM.
- On the last channel group it streams the finished 8-bit output pixel downstream.

Parameters:
- ADDR_W, 18, psum SRAM address width (16 out ch x 112 x 112 = 200704 entries).
- OUT_DEPTH, 4, result FIFO depth (power of 2, >= 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_act  in  32  4 x signed 8-bit activations, lane k at [8k+7:8k]
- in_wgt  in  32  4 x signed 8-bit weights, same lane order
- in_addr  in  ADDR_W  psum address (out_ch*12544 + row*112 + col)
- in_first  in  1  first channel group: old psum treated as 0
- in_last  in  1  last channel group: result also pushed to output
- mem_rd_en  out  1  psum SRAM read strobe
- mem_rd_addr  out  ADDR_W  read address
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd_en
- mem_wr_en  out  1  psum SRAM write strobe
- mem_wr_addr  out  ADDR_W  write address
- mem_wdata  out  8  write data
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  8  finished signed output pixel
- out_addr  out  ADDR_W  address of the finished pixel

Behaviour:
- Reset (async, rst_n=0): in_ready=0, mem_rd_en=0, mem_wr_en=0, out_valid=0, all data/address outputs 0, FIFO empty, pipeline valids 0. in_ready rises the first cycle after reset release.
- Reset mid-operation drops in-flight beats and FIFO contents. No write is issued after reset asserts.
- Beat accepted when in_valid && in_ready.
- S0 (accept cycle T):
  - p_k = sext32(act_k) * sext32(wgt_k); ex = p0+p1+p2+p3 (32-bit).
  - cb = {ex[31], ex[13:7]}, registered.
  - mem_rd_en=1, mem_rd_addr=in_addr in the same cycle T, suppressed when in_first=1.
- S1 (cycle T+1):
  - old = 0 if first, else forwarded value, else mem_rdata.
  - s = sext32(old) + sext32(cb); res = {s[31], s[6:0]}.
  - mem_wr_en=1, mem_wr_addr=addr, mem_wdata=res in cycle T+1.
  - If last, res/addr are pushed into the FIFO at the end of T+1.
- Hazard: if the beat in S1 writes the same address that the beat entering S0 reads, set a forward flag. That beat then uses the registered S1 res instead of mem_rdata. Back-to-back same-address beats are legal at full rate.
- Throughput: 1 beat/cycle, 2-cycle input-to-write latency. out_valid is no earlier than cycle T+2.
- Flow control: in_ready = (fifo_count + s0_last_pending + s1_last_pending) < OUT_DEPTH. The FIFO never overflows and no stage stalls.
- Output FIFO:
  - out_valid = !empty; out_data/out_addr come from the head entry.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - When full, in_ready=0; an in-flight push cannot be lost by construction of in_ready.
- The count is held in a counter of width clog2(OUT_DEPTH)+1, and rd/wr pointers wrap modulo OUT_DEPTH.

Optional Feature:
- PW_PSUM_SAT_EN defined: res = clamp(s, -128, 127) instead of {s[31], s[6:0]}. cb quantization is unchanged.
- Undefined: wrap behaviour exactly as stated, bit-exact to the golden model output file.

Decomposition:
- Package pw_pkg:
  - constants FM_W=112, FM_H=112, CH_IN=32, CH_OUT=16, LANES=4, Q_SHIFT=7;
  - typedef act_t (logic signed [7:0]);
  - typedef psum_t (logic signed [31:0]);
  - function quant8 for the {sign, [13:7]} slice.
- One sub-module: pw_result_fifo (parameterized depth, valid/ready, count output).

Test Plan:
- act=[64,0,0,0], wgt=[64,0,0,0], addr=5, first=1, last=1 -> cb=32, mem_wdata=32 at addr 5, out_data=32/out_addr=5; no mem_rd_en.
- Same beat with wgt=-64 -> ex=-4096, cb=0xE0, out_data=-32.
- Back-to-back beats to addr 9: first=1 then first=0,last=1, each act=wgt=[64,0,0,0] -> forward path used, writes 32 then 64, out_data=64.
- act=wgt=[127,127,127,127] to addr 3: first=1 then first=0,last=1 -> cb=120 each, out_data=112 (0x70). With PW_PSUM_SAT_EN -> 127.
- Hold out_ready=0 while streaming last beats -> exactly OUT_DEPTH results buffered, in_ready=0. Release -> results drain in order with no loss or duplication.
- Full 16x112x112 layer (8 groups per pixel, random data) vs golden output file -> bit-exact. Assert rst_n mid-stream -> all outputs 0 immediately, FIFO empty.

Source files
------------

// File: rtl/pw_pkg.sv
// Shared types, constants and arithmetic helpers for the pointwise partial-sum stage.
// PW_PSUM_SAT_EN selects saturating instead of wrapping requantization of the psum.
package pw_pkg;

    localparam int FM_W    = 112;
    localparam int FM_H    = 112;
    localparam int CH_IN   = 32;
    localparam int CH_OUT  = 16;
    localparam int LANES   = 4;
    localparam int Q_SHIFT = 7;

    typedef logic signed [7:0]  act_t;
    typedef logic signed [31:0] psum_t;

    // Sign bit plus the 7 bits just above the fixed-point shift.
    function automatic logic [7:0] quant8(input psum_t v);
        return {v[31], v[Q_SHIFT+6:Q_SHIFT]};
    endfunction

    function automatic psum_t dot4(input logic [8*LANES-1:0] act,
                                   input logic [8*LANES-1:0] wgt);
        psum_t acc;
        acc = '0;
        for (int k = 0; k < LANES; k++) begin
            acc = acc + psum_t'(act_t'(act[8*k +: 8])) * psum_t'(act_t'(wgt[8*k +: 8]));
        end
        return acc;
    endfunction

    function automatic logic [7:0] requant(input psum_t s);
`ifdef PW_PSUM_SAT_EN
        if (s > psum_t'(127)) begin
            return 8'h7F;
        end else if (s < psum_t'(-128)) begin
            return 8'h80;
        end else begin
            return s[7:0];
        end
`else
        return {s[31], s[6:0]};
`endif
    endfunction

endpackage

// File: rtl/pw_result_fifo.sv
// Result FIFO for finished output pixels: power-of-2 depth, valid/ready pop side.
// Handshake: an entry leaves when out_valid && out_ready; push is dropped only if full.
module pw_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 26
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign do_push   = push && (count != CNT_W'(DEPTH));
    assign do_pop    = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pw_psum_accum.sv
// Pointwise 1x1 partial-sum accumulator: 4-lane dot product, psum SRAM read-modify-write.
// Build option PW_PSUM_SAT_EN saturates the accumulated psum instead of wrapping it.
module pw_psum_accum
    import pw_pkg::*;
#(
    parameter int ADDR_W    = 18,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_act,
    input  logic [31:0]       in_wgt,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_first,
    input  logic              in_last,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [7:0]        mem_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [ADDR_W-1:0] out_addr
);

    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
    localparam int ENT_W = ADDR_W + 8;

    logic              run;
    logic              accept;
    psum_t             ex;
    psum_t             s;

    logic              s1_valid;
    logic              s1_first;
    logic              s1_last;
    logic              s1_fwd;
    logic [7:0]        s1_cb;
    logic [ADDR_W-1:0] s1_addr;
    logic [7:0]        res_q;
    logic [7:0]        old;
    logic [7:0]        res;

    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    pending;
    logic [ENT_W-1:0]  fifo_head;

    // Every last beat already accepted owns a FIFO slot, so a push can never be refused.
    assign pending  = {1'b0, fifo_count} + (CNT_W+1)'(s1_valid && s1_last);
    assign in_ready = run && (pending < (CNT_W+1)'(OUT_DEPTH));
    assign accept   = in_valid && in_ready;

    assign ex          = dot4(in_act, in_wgt);
    assign mem_rd_en   = accept && !in_first;
    assign mem_rd_addr = mem_rd_en ? in_addr : '0;

    always_comb begin
        old = mem_rdata;
        if (s1_first) begin
            old = '0;
        end else if (s1_fwd) begin
            old = res_q;
        end
        s   = psum_t'(act_t'(old)) + psum_t'(act_t'(s1_cb));
        res = requant(s);
    end

    assign mem_wr_en   = s1_valid;
    assign mem_wr_addr = s1_valid ? s1_addr : '0;
    assign mem_wdata   = s1_valid ? res : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 1'b0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_fwd   <= 1'b0;
            s1_cb    <= '0;
            s1_addr  <= '0;
            res_q    <= '0;
        end else begin
            run      <= 1'b1;
            s1_valid <= accept;
            if (accept) begin
                s1_cb    <= quant8(ex);
                s1_addr  <= in_addr;
                s1_first <= in_first;
                s1_last  <= in_last;
                // The SRAM read issued now races the write of the beat in S1.
                s1_fwd   <= s1_valid && (s1_addr == in_addr);
            end
            if (s1_valid) begin
                res_q <= res;
            end
        end
    end

    pw_result_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s1_valid && s1_last),
        .push_data ({s1_addr, res}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fifo_head),
        .count     (fifo_count)
    );

    assign out_data = fifo_head[7:0];
    assign out_addr = fifo_head[ENT_W-1:8];

endmodule

// File: tb/tb_pw_psum_accum.sv
// Self-checking bench for pw_psum_accum with an SRAM model and a behavioural psum model.
// Honours PW_PSUM_SAT_EN for the saturating expectation.
module tb_pw_psum_accum;

    localparam int ADDR_W = 18;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_act;
    logic [31:0]       in_wgt;
    logic [ADDR_W-1:0] in_addr;
    logic              in_first;
    logic              in_last;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [7:0]        mem_rdata = 8'h00;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [7:0]        mem_wdata;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [ADDR_W-1:0] out_addr;

    pw_psum_accum #(.ADDR_W(ADDR_W), .OUT_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_act      (in_act),
        .in_wgt      (in_wgt),
        .in_addr     (in_addr),
        .in_first    (in_first),
        .in_last     (in_last),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rdata   (mem_rdata),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wdata   (mem_wdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_addr    (out_addr)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- psum SRAM (read returns pre-write data) ----------------
    logic [7:0] sram [0:255] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_wr_en) sram[mem_wr_addr[7:0]] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= sram[mem_rd_addr[7:0]];
    end

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [25:0] exp_q[$];
    logic [25:0] wr_exp_q[$];
    logic [7:0]  gold [0:255];
    logic        prev_acc = 1'b0;
    logic [7:0]  last_out_data = '0;
    logic [ADDR_W-1:0] last_out_addr = '0;
    logic [7:0]  wr_hist0 = '0;
    logic [7:0]  wr_hist1 = '0;
    int          rd_cnt = 0;
    logic        rr_mode = 1'b0;
    logic        ready_fixed = 1'b1;
    logic        stop_tx = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [7:0] m_quant(input int ex);
        int v;
        v = ((ex < 0) ? 128 : 0) + ((ex >>> 7) & 127);
        return v[7:0];
    endfunction

    function automatic logic [7:0] m_cb(input logic [31:0] a, input logic [31:0] w);
        int ex;
        ex = 0;
        for (int k = 0; k < 4; k++) ex += int'(byte'(a[8*k +: 8])) * int'(byte'(w[8*k +: 8]));
        return m_quant(ex);
    endfunction

    function automatic logic [7:0] m_res(input logic [7:0] old, input logic [7:0] cb);
        int s;
        int v;
        s = int'(byte'(old)) + int'(byte'(cb));
`ifdef PW_PSUM_SAT_EN
        v = (s > 127) ? 127 : ((s < -128) ? -128 : s);
`else
        v = ((s < 0) ? 128 : 0) + (s & 127);
`endif
        return v[7:0];
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic        acc;
        logic [25:0] e;
        logic [7:0]  old;
        logic [7:0]  r;
        if (rst_n) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < DEPTH});
            if (exp_q.size() == 0) chk("out_spurious", {31'b0, out_valid}, 32'd0);
            else if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                chk("out_data", {24'b0, out_data}, {24'b0, e[7:0]});
                chk("out_addr", {14'b0, out_addr}, {14'b0, e[25:8]});
                last_out_data = out_data;
                last_out_addr = out_addr;
            end
            acc = in_valid && in_ready;
            chk("mem_rd_en", {31'b0, mem_rd_en}, {31'b0, acc && !in_first});
            if (acc && !in_first) chk("mem_rd_addr", {14'b0, mem_rd_addr}, {14'b0, in_addr});
            if (mem_rd_en) rd_cnt++;
            chk("mem_wr_en", {31'b0, mem_wr_en}, {31'b0, prev_acc});
            if (mem_wr_en && wr_exp_q.size() != 0) begin
                e = wr_exp_q.pop_front();
                chk("mem_wr_addr", {14'b0, mem_wr_addr}, {14'b0, e[25:8]});
                chk("mem_wdata", {24'b0, mem_wdata}, {24'b0, e[7:0]});
                wr_hist1 = wr_hist0;
                wr_hist0 = mem_wdata;
            end
            if (acc) begin
                old = in_first ? 8'h00 : gold[in_addr[7:0]];
                r = m_res(old, m_cb(in_act, in_wgt));
                gold[in_addr[7:0]] = r;
                wr_exp_q.push_back({in_addr, r});
                if (in_last) exp_q.push_back({in_addr, r});
            end
            prev_acc = acc;
        end
    end

    // ---------------- out_ready driver ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rr_mode ? ($urandom_range(0, 3) != 0) : ready_fixed;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] a, input logic [31:0] w, input logic [ADDR_W-1:0] ad,
                        input logic f, input logic l);
        int t;
        in_valid = 1'b1;
        in_act   = a;
        in_wgt   = w;
        in_addr  = ad;
        in_first = f;
        in_last  = l;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready && rst_n) break;
            if (stop_tx) break;
            t++;
            if (t > 2000) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        int gap;
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        send($urandom(), $urandom(), ADDR_W'($urandom_range(0, 15)),
             $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || wr_exp_q.size() != 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_results", exp_q.size(), 32'd0);
        chk("drain_writes", wr_exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("ready_low_at_release", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("ready_rises", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic clear_model();
        exp_q.delete();
        wr_exp_q.delete();
        prev_acc = 1'b0;
        for (int i = 0; i < 256; i++) gold[i] = sram[i];
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int rd0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_act   = '0;
        in_wgt   = '0;
        in_addr  = '0;
        in_first = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < 256; i++) gold[i] = 8'h00;
        #2;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
        repeat (3) @(posedge clk);
        release_reset();

        // Pin the model against hand-computed values.
        chk("pin_cb_pos", {24'b0, m_cb(32'h0000_0040, 32'h0000_0040)}, 32'd32);
        chk("pin_cb_neg", {24'b0, m_cb(32'h0000_0040, 32'h0000_00C0)}, 32'hE0);
        chk("pin_cb_max", {24'b0, m_cb(32'h7F7F_7F7F, 32'h7F7F_7F7F)}, 32'd120);

        // Single first+last beat, no SRAM read.
        rd0 = rd_cnt;
        send(32'h0000_0040, 32'h0000_0040, 18'd5, 1'b1, 1'b1);
        drain();
        chk("t1_out_data", {24'b0, last_out_data}, 32'd32);
        chk("t1_out_addr", {14'b0, last_out_addr}, 32'd5);
        chk("t1_wdata", {24'b0, wr_hist0}, 32'd32);
        chk("t1_no_rd", rd_cnt - rd0, 32'd0);

        // Negative weight.
        send(32'h0000_0040, 32'h0000_00C0, 18'd5, 1'b1, 1'b1);
        drain();
        chk("t2_out_data", {24'b0, last_out_data}, 32'hE0);

        // Back-to-back same address: forwarding.
        send(32'h0000_0040, 32'h0000_0040, 18'd9, 1'b1, 1'b0);
        send(32'h0000_0040, 32'h0000_0040, 18'd9, 1'b0, 1'b1);
        drain();
        chk("t3_wr_first", {24'b0, wr_hist1}, 32'd32);
        chk("t3_wr_second", {24'b0, wr_hist0}, 32'd64);
        chk("t3_out_data", {24'b0, last_out_data}, 32'd64);

        // Largest positive products: wrap vs saturate.
        send(32'h7F7F_7F7F, 32'h7F7F_7F7F, 18'd3, 1'b1, 1'b0);
        send(32'h7F7F_7F7F, 32'h7F7F_7F7F, 18'd3, 1'b0, 1'b1);
        drain();
`ifdef PW_PSUM_SAT_EN
        chk("t4_out_data", {24'b0, last_out_data}, 32'h7F);
`else
        chk("t4_out_data", {24'b0, last_out_data}, 32'h70);
`endif

        // Backpressure: FIFO fills to DEPTH, in_ready drops, then drains in order.
        ready_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) send($urandom(), $urandom(), ADDR_W'(10 + i), 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_buffered", exp_q.size(), DEPTH);
        chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        ready_fixed = 1'b1;
        drain();
        repeat (4) @(posedge clk);
        #1;

        // Randomized traffic with random downstream readiness.
        rr_mode = 1'b1;
        repeat (1500) send_rand();
        drain();

        // Reset in the middle of traffic.
        stop_tx = 1'b0;
        fork
            begin
                while (!stop_tx) send_rand();
            end
            begin
                repeat (30) @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
                chk("mid_rst_rd_en", {31'b0, mem_rd_en}, 32'd0);
                chk("mid_rst_rd_addr", {14'b0, mem_rd_addr}, 32'd0);
                chk("mid_rst_wr_en", {31'b0, mem_wr_en}, 32'd0);
                chk("mid_rst_wr_addr", {14'b0, mem_wr_addr}, 32'd0);
                chk("mid_rst_wdata", {24'b0, mem_wdata}, 32'd0);
                chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
                chk("mid_rst_out_data", {24'b0, out_data}, 32'd0);
                chk("mid_rst_out_addr", {14'b0, out_addr}, 32'd0);
                clear_model();
                repeat (3) @(posedge clk);
                stop_tx = 1'b1;
            end
        join
        clear_model();
        release_reset();
        chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);

        repeat (300) send_rand();
        drain();
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
